// File: rtl/riscv_mem_pkg.sv
// Shared RV32I load/store width codes, unit state encoding and access legality check.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  // Legal width code for the direction and naturally aligned for that width.
  function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    logic ok;
    case (f3)
      F3_LB:   ok = 1'b1;
      F3_LH:   ok = ~addr_lo[0];
      F3_LW:   ok = (addr_lo == 2'b00);
      F3_LBU:  ok = ~we;
      F3_LHU:  ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Execute-stage request, memory port and response signals of the load/store unit.
interface mem_access_unit_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [2:0]       req_func3;
  logic             mem_en;
  logic             mem_gnt;
  logic [WIDTH-1:0] mem_addr;
  logic [3:0]       mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic [1:0]       resp_addr_lo;
  logic [2:0]       resp_func3;
  logic             resp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_func3,
           mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_en, mem_addr, mem_we, mem_wdata,
           resp_valid, resp_rdata, resp_addr_lo, resp_func3, resp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_func3,
           mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_en, mem_addr, mem_we, mem_wdata,
           resp_valid, resp_rdata, resp_addr_lo, resp_func3, resp_err
  );
endinterface

// File: rtl/mem_store_mask.sv
// Byte-enable and lane-replicated write data for SB/SH/SW stores.
module mem_store_mask
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_we,
  output logic [31:0] o_wdata
);

  always_comb begin
    o_we    = '0;
    o_wdata = '0;
    case (i_func3)
      F3_SB: begin
        o_we    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_SH: begin
        o_we    = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_wdata[15:0]}};
      end
      F3_SW: begin
        o_we    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one access, checks legality, drives one memory op, returns a response pulse.
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_access_unit_if.slave   bus
);

  state_t           r_state;
  state_t           w_next;
  logic             r_we;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [2:0]       r_func3;
  logic             r_resp_valid;
  logic             r_resp_err;
  logic [WIDTH-1:0] r_resp_rdata;

  logic             w_accept;
  logic             w_legal;
  logic [3:0]       w_we;
  logic [31:0]      w_wdata;

  assign w_accept = bus.req_valid && (r_state == ST_IDLE);
  assign w_legal  = access_ok(bus.req_we, bus.req_func3, bus.req_addr[1:0]);

  mem_store_mask u_store_mask (
    .i_addr_lo (r_addr[1:0]),
    .i_func3   (r_func3),
    .i_wdata   (r_wdata),
    .o_we      (w_we),
    .o_wdata   (w_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = w_legal ? ST_ISSUE : ST_ERR;
      ST_ISSUE: if (bus.mem_gnt) w_next = r_we ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (bus.mem_rvalid) w_next = ST_IDLE;
      ST_ERR:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Error responses are registered at accept so the pulse lands in the single ERR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_func3      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_func3 <= bus.req_func3;
        if (!w_legal) begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_resp_rdata <= '0;
        end
      end
      if ((r_state == ST_ISSUE) && bus.mem_gnt && r_we) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= '0;
      end
      if ((r_state == ST_WAIT) && bus.mem_rvalid) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.req_ready    = (r_state == ST_IDLE);
  assign bus.mem_en       = (r_state == ST_ISSUE);
  assign bus.mem_addr     = {r_addr[WIDTH-1:2], 2'b00};
  assign bus.mem_we       = ((r_state == ST_ISSUE) && r_we) ? w_we : 4'b0000;
  assign bus.mem_wdata    = w_wdata;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_err     = r_resp_err;
  assign bus.resp_rdata   = r_resp_rdata;
  assign bus.resp_addr_lo = r_addr[1:0];
  assign bus.resp_func3   = r_func3;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, misaligned/illegal accesses and reset in WAIT.
module tb_mem_access_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_access_unit_if #(.WIDTH(32)) bus();

  mem_access_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_func3 = f3;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_func3  = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    tick();
    tick();
    check_eq("rst_mem_en", bus.mem_en, 0);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    check_eq("rst_mem_we", bus.mem_we, 0);

    // stale read response right after reset must be ignored
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    check_eq("post_rst_ready", bus.req_ready, 1);
    tick();
    check_eq("stale_rvalid_resp", bus.resp_valid, 0);
    check_eq("stale_rvalid_ready", bus.req_ready, 1);
    bus.mem_rvalid = 1'b0;

    // SW 0x100
    present(1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010);
    bus.mem_gnt = 1'b1;
    check_eq("sw_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    check_eq("sw_mem_en", bus.mem_en, 1);
    check_eq("sw_mem_we", bus.mem_we, 32'hF);
    check_eq("sw_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check_eq("sw_mem_addr", bus.mem_addr, 32'h100);
    check_eq("sw_resp_early", bus.resp_valid, 0);
    tick();
    check_eq("sw_resp_valid", bus.resp_valid, 1);
    check_eq("sw_resp_err", bus.resp_err, 0);
    check_eq("sw_resp_rdata", bus.resp_rdata, 0);
    check_eq("sw_mem_en_off", bus.mem_en, 0);
    tick();
    check_eq("sw_resp_pulse", bus.resp_valid, 0);

    // SB 0x103
    present(1'b1, 32'h103, 32'h0000_00A5, 3'b000);
    tick();
    bus.req_valid = 1'b0;
    check_eq("sb_mem_we", bus.mem_we, 32'h8);
    check_eq("sb_mem_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    check_eq("sb_mem_addr", bus.mem_addr, 32'h100);
    tick();
    check_eq("sb_resp_valid", bus.resp_valid, 1);

    // SH 0x102
    present(1'b1, 32'h102, 32'hFFFF_1234, 3'b001);
    tick();
    bus.req_valid = 1'b0;
    check_eq("sh_mem_we", bus.mem_we, 32'hC);
    check_eq("sh_mem_wdata", bus.mem_wdata, 32'h1234_1234);
    tick();
    check_eq("sh_resp_valid", bus.resp_valid, 1);
    bus.mem_gnt = 1'b0;

    // LH 0x202, grant after 3 wait cycles, rvalid 2 cycles after grant
    present(1'b0, 32'h202, 32'h0, 3'b001);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("lh_mem_en_c%0d", i), bus.mem_en, 1);
      if (i == 3) bus.mem_gnt = 1'b1;
      else tick();
    end
    check_eq("lh_mem_we", bus.mem_we, 0);
    check_eq("lh_mem_addr", bus.mem_addr, 32'h200);
    tick();
    bus.mem_gnt = 1'b0;
    check_eq("lh_wait_en", bus.mem_en, 0);
    check_eq("lh_wait_resp", bus.resp_valid, 0);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h8001_7FFF;
    tick();
    bus.mem_rvalid = 1'b0;
    check_eq("lh_resp_valid", bus.resp_valid, 1);
    check_eq("lh_resp_rdata", bus.resp_rdata, 32'h8001_7FFF);
    check_eq("lh_resp_addr_lo", bus.resp_addr_lo, 2);
    check_eq("lh_resp_func3", bus.resp_func3, 3'b001);
    check_eq("lh_resp_err", bus.resp_err, 0);
    tick();
    check_eq("lh_resp_pulse", bus.resp_valid, 0);
    check_eq("lh_addr_lo_hold", bus.resp_addr_lo, 2);

    // LBU 0x303, minimum latency
    present(1'b0, 32'h303, 32'h0, 3'b100);
    bus.mem_gnt = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check_eq("lbu_mem_en", bus.mem_en, 1);
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1122_3344;
    check_eq("lbu_resp_early", bus.resp_valid, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    check_eq("lbu_resp_valid", bus.resp_valid, 1);
    check_eq("lbu_resp_rdata", bus.resp_rdata, 32'h1122_3344);
    check_eq("lbu_resp_addr_lo", bus.resp_addr_lo, 3);
    check_eq("lbu_resp_func3", bus.resp_func3, 3'b100);

    // misaligned LW 0x101
    present(1'b0, 32'h101, 32'h0, 3'b010);
    tick();
    bus.req_valid = 1'b0;
    check_eq("mis_mem_en", bus.mem_en, 0);
    check_eq("mis_resp_valid", bus.resp_valid, 1);
    check_eq("mis_resp_err", bus.resp_err, 1);
    check_eq("mis_resp_rdata", bus.resp_rdata, 0);
    check_eq("mis_ready_err", bus.req_ready, 0);
    tick();
    check_eq("mis_resp_pulse", bus.resp_valid, 0);
    check_eq("mis_ready_back", bus.req_ready, 1);
    check_eq("mis_mem_en_after", bus.mem_en, 0);

    // illegal store func3 011
    present(1'b1, 32'h100, 32'hFFFF_FFFF, 3'b011);
    tick();
    bus.req_valid = 1'b0;
    check_eq("ill_resp_err", bus.resp_err, 1);
    check_eq("ill_resp_valid", bus.resp_valid, 1);
    check_eq("ill_mem_we", bus.mem_we, 0);
    check_eq("ill_mem_en", bus.mem_en, 0);
    tick();
    check_eq("ill_mem_we_after", bus.mem_we, 0);

    // misaligned LHU 0x201
    present(1'b0, 32'h201, 32'h0, 3'b101);
    tick();
    bus.req_valid = 1'b0;
    check_eq("lhu_mis_err", bus.resp_err, 1);
    tick();

    // reset while waiting for read data, then a late rvalid
    present(1'b0, 32'h300, 32'h0, 3'b010);
    bus.mem_gnt = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.mem_gnt = 1'b0;
    check_eq("rw_in_wait_ready", bus.req_ready, 0);
    check_eq("rw_in_wait_en", bus.mem_en, 0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rw_async_ready", bus.req_ready, 1);
    check_eq("rw_async_func3", bus.resp_func3, 0);
    tick();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    check_eq("rw_ready_after", bus.req_ready, 1);
    tick();
    bus.mem_rvalid = 1'b0;
    check_eq("rw_late_resp", bus.resp_valid, 0);
    check_eq("rw_late_rdata", bus.resp_rdata, 0);
    check_eq("rw_ready_hold", bus.req_ready, 1);
    tick();
    check_eq("rw_late_resp2", bus.resp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
